// File: rtl/router_pkg.sv
// Shared constants and helpers for the router crossbar.
package router_pkg;

  localparam int unsigned NPORTS_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned STAT_W     = 16;

  // Index width for n ports, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: one-hot grant, priority rotates past the last winner
// only when the caller reports that the granted word actually moved.
module rr_arb #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_next_ptr;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;

  // Scan requests starting at the current priority pointer.
  always_comb begin
    grant      = '0;
    w_next_ptr = r_ptr;
    w_idx      = '0;
    w_found    = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IDX_W'((32'(r_ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_next_ptr   = IDX_W'((32'(w_idx) + 1) % N);
      end
    end
  end

  // Priority pointer; reset gives input 0 top priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/router_xbar.sv
// NPORTS x NPORTS crossbar with one show-ahead FIFO and one round-robin
// arbiter per output. Optional macro ROUTER_XBAR_STATS_EN adds stat_cnt,
// a saturating per-output count of pushed words.
module router_xbar
  import router_pkg::*;
#(
  parameter int unsigned NPORTS = NPORTS_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NPORTS-1:0]                in_vld,
  input  logic [NPORTS*addr_w(NPORTS)-1:0] in_addr,
  input  logic [NPORTS*DATA_W-1:0]         in_data,
  output logic [NPORTS-1:0]                in_rdy,
  input  logic [NPORTS-1:0]                out_pop,
  output logic [NPORTS*DATA_W-1:0]         out_data,
  output logic [NPORTS-1:0]                out_rdy,
  output logic [NPORTS-1:0]                out_full
`ifdef ROUTER_XBAR_STATS_EN
  ,
  output logic [NPORTS*STAT_W-1:0]         stat_cnt
`endif
);

  localparam int unsigned ADDR_W = addr_w(NPORTS);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  logic [NPORTS-1:0][NPORTS-1:0] w_req;    // [output][input]
  logic [NPORTS-1:0][NPORTS-1:0] w_grant;  // [output][input]
  logic [NPORTS-1:0]             w_push;
  logic [NPORTS-1:0]             w_pop;
  logic [NPORTS-1:0]             w_full;
  logic [NPORTS-1:0]             w_nempty;

  // Request matrix; out-of-range addresses match no output and so stall.
  always_comb begin
    w_req = '0;
    for (int unsigned o = 0; o < NPORTS; o++) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        w_req[o][i] = in_vld[i] && (in_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(o));
      end
    end
  end

  // Accept only the granted input of a FIFO that is not full at cycle start.
  always_comb begin
    in_rdy = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      for (int unsigned o = 0; o < NPORTS; o++) begin
        if (w_grant[o][i] && !w_full[o] && !reset) begin
          in_rdy[i] = 1'b1;
        end
      end
    end
  end

  assign out_rdy  = w_nempty & ~{NPORTS{reset}};
  assign out_full = w_full & ~{NPORTS{reset}};

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    rr_arb #(.N(NPORTS)) u_arb (
      .clock   (clock),
      .reset   (reset),
      .req     (w_req[g]),
      .advance (w_push[g]),
      .grant   (w_grant[g])
    );

    assign w_full[g]   = (r_cnt == CNT_W'(DEPTH));
    assign w_nempty[g] = (r_cnt != '0);
    assign w_push[g]   = (|w_grant[g]) && !w_full[g] && !reset;
    assign w_pop[g]    = out_pop[g] && w_nempty[g] && !reset;
    assign out_data[g*DATA_W +: DATA_W] = r_mem[r_rptr];

    // Select the granted input's payload.
    always_comb begin
      w_wdata = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
        if (w_grant[g][i]) begin
          w_wdata = in_data[i*DATA_W +: DATA_W];
        end
      end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
      if (w_push[g]) begin
        r_mem[r_wptr] <= w_wdata;
      end
    end

    // Pointers and occupancy; pop on empty is filtered out by w_pop.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push[g]) r_wptr <= r_wptr + PTR_W'(1);
        if (w_pop[g])  r_rptr <= r_rptr + PTR_W'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt <= r_cnt + CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end

`ifdef ROUTER_XBAR_STATS_EN
    logic [STAT_W-1:0] r_stat;

    // Saturating count of words pushed into this output.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_stat <= '0;
      end else if (w_push[g] && (r_stat != '1)) begin
        r_stat <= r_stat + STAT_W'(1);
      end
    end

    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat;
`endif
  end

endmodule

// File: tb/tb_router_xbar.sv
// Bench for router_xbar: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_router_xbar;

  localparam int NP  = 8;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int DEP = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NP-1:0]    in_vld = '0;
  logic [NP*AW-1:0] in_addr = '0;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]    in_rdy;
  logic [NP-1:0]    out_pop = '0;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_rdy;
  logic [NP-1:0]    out_full;
`ifdef ROUTER_XBAR_STATS_EN
  logic [NP*16-1:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  router_xbar #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_vld   (in_vld),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .out_pop  (out_pop),
    .out_data (out_data),
    .out_rdy  (out_rdy),
    .out_full (out_full)
`ifdef ROUTER_XBAR_STATS_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one queue per output, last winner per output.
  logic [DW-1:0] mq [NP][$];
  int            mlast [NP];
  int            mstat [NP];
  logic [NP-1:0] e_rdy, e_ordy, e_full;
  int            m_win, m_i, m_a;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_in_rdy", 64'(in_rdy), 64'(0));
      chk("rst_out_rdy", 64'(out_rdy), 64'(0));
      chk("rst_out_full", 64'(out_full), 64'(0));
      for (int o = 0; o < NP; o++) begin
        mq[o].delete();
        mlast[o] = NP - 1;
        mstat[o] = 0;
      end
    end else begin
      e_rdy = '0;
      for (int o = 0; o < NP; o++) begin
        m_win = -1;
        for (int k = 0; k < NP; k++) begin
          m_i = (mlast[o] + 1 + k) % NP;
          if (m_win < 0 && in_vld[m_i] && int'(in_addr[m_i*AW +: AW]) == o) m_win = m_i;
        end
        if (m_win >= 0 && mq[o].size() < DEP) e_rdy[m_win] = 1'b1;
        e_ordy[o] = (mq[o].size() > 0);
        e_full[o] = (mq[o].size() == DEP);
      end
      chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
      chk("out_rdy", 64'(out_rdy), 64'(e_ordy));
      chk("out_full", 64'(out_full), 64'(e_full));
      for (int o = 0; o < NP; o++) begin
        if (e_ordy[o]) chk($sformatf("out_data[%0d]", o), 64'(out_data[o*DW +: DW]), 64'(mq[o][0]));
`ifdef ROUTER_XBAR_STATS_EN
        chk($sformatf("stat_cnt[%0d]", o), 64'(stat_cnt[o*16 +: 16]),
            64'((mstat[o] > 65535) ? 65535 : mstat[o]));
`endif
      end
      for (int o = 0; o < NP; o++) begin
        if (out_pop[o] && mq[o].size() > 0) void'(mq[o].pop_front());
      end
      for (int i = 0; i < NP; i++) begin
        if (e_rdy[i]) begin
          m_a = int'(in_addr[i*AW +: AW]);
          mq[m_a].push_back(in_data[i*DW +: DW]);
          mlast[m_a] = i;
          mstat[m_a]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input int i, input int a, input logic [DW-1:0] d);
    in_vld[i] = 1'b1;
    in_addr[i*AW +: AW] = AW'(a);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic clr();
    in_vld = '0;
  endtask

  int ord [6] = '{0, 3, 6, 0, 3, 6};

  initial begin
    // Reset with a pending request: nothing may be accepted.
    drv(0, 0, 32'h0BAD_0000);
    repeat (3) step();
    @(negedge clock);
    chk("lit_rst_in_rdy", 64'(in_rdy), 64'(0));
    chk("lit_rst_out_rdy", 64'(out_rdy), 64'(0));
    step();
    clr();
    reset = 1'b0;

    // Single word, input 2 -> output 5, latency 1.
    step();
    drv(2, 5, 32'hA5A5_0001);
    @(negedge clock);
    chk("lit_single_in_rdy", 64'(in_rdy), 64'h04);
    step();
    clr();
    @(negedge clock);
    chk("lit_single_out_rdy5", 64'(out_rdy[5]), 64'(1));
    chk("lit_single_out_data5", 64'(out_data[5*DW +: DW]), 64'h0000_0000_A5A5_0001);
    step();
    out_pop[5] = 1'b1;
    step();
    out_pop[5] = 1'b0;

    // Three inputs contend for output 1: round-robin 0,3,6,0,3,6.
    out_pop[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      drv(0, 1, 32'h1000_0000 + 32'(c * 16));
      drv(3, 1, 32'h1000_0003 + 32'(c * 16));
      drv(6, 1, 32'h1000_0006 + 32'(c * 16));
      @(negedge clock);
      chk($sformatf("lit_rr_grant%0d", c), 64'(in_rdy), 64'(8'(1 << ord[c])));
    end
    step();
    clr();
    repeat (2) step();
    out_pop[1] = 1'b0;

    // Fill output 4, then confirm a same-cycle pop does not free space.
    step();
    for (int k = 0; k < 16; k++) begin
      drv(1, 4, 32'h4000_0000 + 32'(k));
      step();
    end
    drv(1, 4, 32'h4000_0010);
    @(negedge clock);
    chk("lit_full_out_full4", 64'(out_full[4]), 64'(1));
    chk("lit_full_in_rdy1", 64'(in_rdy[1]), 64'(0));
    step();
    out_pop[4] = 1'b1;
    @(negedge clock);
    chk("lit_full_pop_no_pass", 64'(in_rdy[1]), 64'(0));
    step();
    out_pop[4] = 1'b0;
    @(negedge clock);
    chk("lit_full_after_pop_rdy", 64'(in_rdy[1]), 64'(1));
    chk("lit_full_after_pop_full", 64'(out_full[4]), 64'(0));
    step();
    clr();
    out_pop[4] = 1'b1;
    repeat (16) step();
    out_pop[4] = 1'b0;
    @(negedge clock);
    chk("lit_drain_out_rdy4", 64'(out_rdy[4]), 64'(0));

    // Streaming push+pop on output 7 across pointer wrap.
    step();
    drv(5, 7, 32'h7000_0000);
    step();
    for (int k = 1; k <= 40; k++) begin
      drv(5, 7, 32'h7000_0000 + 32'(k));
      out_pop[7] = 1'b1;
      step();
    end
    clr();
    @(negedge clock);
    chk("lit_stream_out_rdy7", 64'(out_rdy[7]), 64'(1));
    chk("lit_stream_head7", 64'(out_data[7*DW +: DW]), 64'h0000_0000_7000_0028);
    step();
    out_pop[7] = 1'b0;

    // Reset mid-operation with 3 words stored in output 0.
    for (int k = 0; k < 3; k++) begin
      drv(0, 0, 32'h8000_0000 + 32'(k));
      step();
    end
    drv(3, 0, 32'h8000_0033);
    reset = 1'b1;
    @(negedge clock);
    chk("lit_midrst_in_rdy", 64'(in_rdy), 64'(0));
    step();
    @(negedge clock);
    chk("lit_midrst_out_rdy0", 64'(out_rdy[0]), 64'(0));
    chk("lit_midrst_in_rdy2", 64'(in_rdy), 64'(0));
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("lit_midrst_first_grant", 64'(in_rdy), 64'h01);
    step();
    clr();

    // All outputs accept one word each in the same cycle.
    for (int i = 0; i < NP; i++) drv(i, (i + 1) % NP, 32'h9000_0000 + 32'(i));
    @(negedge clock);
    chk("lit_parallel_in_rdy", 64'(in_rdy), 64'hFF);
    step();
    clr();
    out_pop = '1;
    @(negedge clock);
    chk("lit_parallel_out_rdy", 64'(out_rdy), 64'hFF);
    step();
    out_pop = '0;

`ifdef ROUTER_XBAR_STATS_EN
    // Saturate the push counter of output 2.
    drv(0, 2, 32'h2222_0000);
    out_pop[2] = 1'b1;
    repeat (70000) step();
    clr();
    step();
    out_pop[2] = 1'b0;
    @(negedge clock);
    chk("lit_stat_sat2", 64'(stat_cnt[2*16 +: 16]), 64'hFFFF);
`endif

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
